srt_div_iter: RTL and testbench

Iterative radix-4 unsigned divider core for the SRT divider. It owns the partial-remainder register and the quotient accumulator, and runs one iteration per clock. Each iteration presents the shifted 26-bit partial remainder and the divisor to the digit-selection ladder (compare against d, 2d, 3d), subtracts the selected multiple and appends the 2-bit digit to the quotient. Operands arrive and results leave over valid/ready handshakes.

---
 rtl/srt_div_iter.sv | 147 ++++++++++++++
 tb/tb_srt_div_iter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/srt_div_iter.sv
// Iterative radix-4 unsigned divider core.
// Owns the partial remainder W, the dividend shift register X and the
// quotient accumulator Q, and retires one 2-bit quotient digit per clock.
// Operands and results move over valid/ready handshakes.
module srt_div_iter #(
    parameter int N    = 24,
    parameter int ITER = N / 2,
    parameter int RW   = N + 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = $clog2(ITER + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(ITER - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [N-1:0]    d_q;
    logic [N-1:0]    x_q;
    logic [RW-1:0]   w_q;
    logic [N-1:0]    q_q;
    logic [CW-1:0]   cnt_q;
    logic            dbz_q;
    logic [N-1:0]    quo_q;
    logic [N-1:0]    rem_q;

    logic [RW-1:0]   w4_s;
    logic [RW:0]     w4_e_s;
    logic [RW:0]     d1_s;
    logic [RW:0]     d2_s;
    logic [RW:0]     d3_s;
    logic [1:0]      digit_s;
    logic [RW-1:0]   sub_s;
    logic [RW-1:0]   w_d;
    logic [N-1:0]    q_d;

    // Digit-selection ladder: shift in two dividend bits, pick the largest
    // multiple of D not exceeding W4 (compared one bit wider so 3D fits).
    always_comb begin
        w4_s    = (w_q << 2) | {{(RW-2){1'b0}}, x_q[N-1:N-2]};
        w4_e_s  = {1'b0, w4_s};
        d1_s    = {{(RW+1-N){1'b0}}, d_q};
        d2_s    = d1_s << 1;
        d3_s    = d1_s + d2_s;
        digit_s = 2'd0;
        sub_s   = '0;
        if (w4_e_s >= d3_s) begin
            digit_s = 2'd3;
            sub_s   = d3_s[RW-1:0];
        end else if (w4_e_s >= d2_s) begin
            digit_s = 2'd2;
            sub_s   = d2_s[RW-1:0];
        end else if (w4_e_s >= d1_s) begin
            digit_s = 2'd1;
            sub_s   = d1_s[RW-1:0];
        end else begin
            digit_s = 2'd0;
            sub_s   = '0;
        end
        w_d = w4_s - sub_s;
        q_d = (q_q << 2) | {{(N-2){1'b0}}, digit_s};
    end

    // Control FSM plus datapath registers; results are captured on DONE entry.
    // A zero divisor spends one cycle in RUN so its result appears one cycle
    // after acceptance, without touching the iteration datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            d_q     <= '0;
            x_q     <= '0;
            w_q     <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        d_q     <= divisor;
                        x_q     <= dividend;
                        w_q     <= '0;
                        q_q     <= '0;
                        cnt_q   <= '0;
                        dbz_q   <= (divisor == '0);
                        state_q <= S_RUN;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (dbz_q) begin
                        quo_q   <= '1;
                        rem_q   <= x_q;
                        state_q <= S_DONE;
                    end else begin
                        w_q   <= w_d;
                        x_q   <= x_q << 2;
                        q_q   <= q_d;
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == LAST_ITER) begin
                            quo_q   <= q_d;
                            rem_q   <= w_d[N-1:0];
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_RUN;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_srt_div_iter.sv
// Self-checking bench for srt_div_iter: scoreboard of expected results,
// directed latency/extreme/backpressure/reset cases and random stalls.
module tb_srt_div_iter;

    localparam int N = 24;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dbz;
        logic [N-1:0] d;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    bit   rnd_mode    = 1'b0;
    logic ready_force = 1'b1;

    srt_div_iter #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Consumer handshake: random in random mode, otherwise forced level.
    always @(posedge clk) begin
        #2;
        out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : ready_force;
    end

    // Result monitor: compare every consumed result against the scoreboard.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check_val("unexpected_result", 64'd1, 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check_val("quotient", quotient, mon_e.q);
                check_val("remainder", remainder, mon_e.r);
                check_val("div_by_zero", div_by_zero, mon_e.dbz);
                if (!mon_e.dbz) check_val("rem_lt_div", remainder < mon_e.d, 1'b1);
            end
        end
    end

    // Issue one operation; if exp_lat > 0, measure cycles until out_valid.
    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input int exp_lat);
        int   k;
        exp_t e;
        k = 0;
        while (!in_ready && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check_val("in_ready_wait", in_ready, 1'b1);
        if (!in_ready) return;
        e.q   = (b == '0) ? {N{1'b1}} : a / b;
        e.r   = (b == '0) ? a : a % b;
        e.dbz = (b == '0);
        e.d   = b;
        sb_q.push_back(e);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        dividend = N'($urandom);
        divisor  = N'($urandom);
        if (exp_lat > 0) begin
            k = 0;
            while (!out_valid && k < 60) begin
                @(posedge clk); #1;
                k++;
                if (k == 1) check_val("in_ready_low", in_ready, 1'b0);
            end
            check_val("latency", k, exp_lat);
        end
    endtask

    initial begin
        logic [N-1:0] ea;
        logic [N-1:0] eb;
        logic [N-1:0] bp_q;
        logic [N-1:0] bp_r;
        int           k;

        rst      = 1'b1;
        in_valid = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_in_ready", in_ready, 1'b1);
        check_val("rst_out_valid", out_valid, 1'b0);
        check_val("rst_quotient", quotient, 24'h0);
        check_val("rst_remainder", remainder, 24'h0);
        check_val("rst_dbz", div_by_zero, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases with latency checks.
        do_op(24'h000064, 24'h000007, 12);
        do_op(24'hFFFFFF, 24'h000001, 12);
        do_op(24'hFFFFFF, 24'hFFFFFF, 12);
        do_op(24'h000005, 24'h000009, 12);
        do_op(24'hFFFFFF, 24'h000003, 12);
        do_op(24'h123456, 24'h000000, 1);

        // Backpressure: result held for 5 cycles, inputs ignored.
        @(posedge clk); #1;
        ready_force = 1'b0;
        do_op(24'h0ABCDE, 24'h000123, 12);
        bp_q = 24'h0ABCDE / 24'h000123;
        bp_r = 24'h0ABCDE % 24'h000123;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            in_valid = 1'($urandom_range(0, 1));
            dividend = N'($urandom);
            divisor  = N'($urandom);
            check_val("bp_quotient", quotient, bp_q);
            check_val("bp_remainder", remainder, bp_r);
            check_val("bp_dbz", div_by_zero, 1'b0);
            check_val("bp_in_ready", in_ready, 1'b0);
            check_val("bp_out_valid", out_valid, 1'b1);
        end
        in_valid    = 1'b0;
        ready_force = 1'b1;
        @(posedge clk); #1;
        check_val("bp_idle_in_ready", in_ready, 1'b1);
        check_val("bp_idle_out_valid", out_valid, 1'b0);

        // Reset between E6 and E7 of 1000 / 3.
        do_op(24'd1000, 24'd3, 0);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_val("mid_rst_out_valid", out_valid, 1'b0);
        check_val("mid_rst_in_ready", in_ready, 1'b1);
        sb_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        do_op(24'd1000, 24'd3, 12);

        // Random operands with random input gaps and output stalls.
        @(posedge clk); #1;
        rnd_mode = 1'b1;
        for (int i = 0; i < 2500; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            ea = N'($urandom);
            case ($urandom_range(0, 4))
                0:       eb = N'($urandom_range(1, 15));
                1:       eb = ea >> $urandom_range(0, 23);
                2:       eb = ($urandom_range(0, 15) == 0) ? 24'h0 : N'($urandom_range(1, 4095));
                default: eb = N'($urandom);
            endcase
            do_op(ea, eb, 0);
        end
        k = 0;
        while (sb_q.size() != 0 && k < 500) begin
            @(posedge clk); #1;
            k++;
        end
        check_val("drain", sb_q.size(), 0);
        rnd_mode = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
